// File: rtl/p_alu_pipe.sv
// p_alu_pipe: two-stage pipelined logic/arithmetic unit with valid/ready handshakes.
//
// Stage 1 registers an operand beat (A, B, Op). Stage 2 computes and registers
// Result/Carry/Zero. Back-pressure from Out_ready stalls stage 2 first, then stage 1.
// An optional internal accumulator serves opcode 101 (ACC).
//
// Parameters:
//   WIDTH   operand/result/accumulator width (>= 2)
//   ACC_EN  1 builds the accumulator; 0 turns ACC into PASS A and ignores Acc_clr
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      synchronous active-low reset
//   In_valid   operand beat valid
//   In_ready   unit can accept a beat this cycle
//   A, B       operands
//   Op         opcode, sampled with A/B
//   Acc_clr    synchronous accumulator clear
//   Out_valid  Result/Carry/Zero valid
//   Out_ready  consumer accepts result
//   Result     registered result
//   Carry      carry/borrow flag
//   Zero       Result == 0
module p_alu_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ACC_EN = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    input  logic             Acc_clr,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero
);

    localparam logic [2:0] OpXor  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpAdd  = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpAcc  = 3'b101;
    localparam logic [2:0] OpPass = 3'b110;
    localparam logic [2:0] OpNor  = 3'b111;

    // Stage 1 state
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;

    // Stage 2 state
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_base;

    logic             adv2;
    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;
    logic [WIDTH:0]   sum;

    // Stage 2 can take new content when it is empty or its beat leaves this cycle.
    assign adv2     = !out_valid_q || Out_ready;
    assign In_ready = Rst_n && (!s1_valid_q || adv2);
    assign accept   = In_valid && In_ready;
    assign commit   = s1_valid_q && adv2;

    // A clear coincident with an ACC commit takes effect before the add.
    assign acc_base = ((ACC_EN != 0) && Acc_clr) ? '0 : acc_q;

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        sum      = '0;
        unique case (s1_op_q)
            OpXor:  result_d = s1_a_q ^ s1_b_q;
            OpOr:   result_d = s1_a_q | s1_b_q;
            OpAnd:  result_d = s1_a_q & s1_b_q;
            OpAdd: begin
                sum      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OpSub: begin
                // The extra top bit of the widened difference is the unsigned borrow.
                sum      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OpAcc: begin
                if (ACC_EN != 0) begin
                    sum      = {1'b0, acc_base} + {1'b0, s1_a_q};
                    result_d = sum[WIDTH-1:0];
                    carry_d  = sum[WIDTH];
                end else begin
                    result_d = s1_a_q;
                end
            end
            OpPass: result_d = s1_a_q;
            OpNor:  result_d = ~(s1_a_q | s1_b_q);
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    // Accumulator only moves on a committing ACC beat; a stalled beat never touches it.
    always_comb begin
        acc_d = '0;
        if (ACC_EN != 0) begin
            if (commit && (s1_op_q == OpAcc)) begin
                acc_d = result_d;
            end else begin
                acc_d = acc_base;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OpXor;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= A;
                s1_b_q     <= B;
                s1_op_q    <= Op;
            end else if (commit) begin
                s1_valid_q <= 1'b0;
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
            end
            if (commit) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= zero_d;
            end
            acc_q <= acc_d;
        end
    end

    assign Out_valid = out_valid_q;
    assign Result    = result_q;
    assign Carry     = carry_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_p_alu_pipe.sv
// Testbench for p_alu_pipe: two instances (ACC_EN=1 and ACC_EN=0) share all inputs.
// A behavioural model tracks beats through the pipe and is compared on every cycle;
// directed sequences additionally check hand-computed literal results.
module tb_p_alu_pipe;

    localparam int unsigned W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         In_valid;
    logic         In_ready;
    logic         In_ready0;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Op;
    logic         Acc_clr;
    logic         Out_valid;
    logic         Out_valid0;
    logic         Out_ready;
    logic [W-1:0] Result;
    logic [W-1:0] Result0;
    logic         Carry;
    logic         Carry0;
    logic         Zero;
    logic         Zero0;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    p_alu_pipe #(.WIDTH(W), .ACC_EN(1)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .Acc_clr   (Acc_clr),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Result    (Result),
        .Carry     (Carry),
        .Zero      (Zero)
    );

    p_alu_pipe #(.WIDTH(W), .ACC_EN(0)) dut0 (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready0),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .Acc_clr   (Acc_clr),
        .Out_valid (Out_valid0),
        .Out_ready (Out_ready),
        .Result    (Result0),
        .Carry     (Carry0),
        .Zero      (Zero0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference for one operation.
    function automatic void alu(input logic [2:0] op, input int a, input int b, input int acc_in,
                                input bit acc_en, output int res, output bit c);
        c = 1'b0;
        case (op)
            3'd0: res = a ^ b;
            3'd1: res = a | b;
            3'd2: res = a & b;
            3'd3: begin res = (a + b) % 256; c = (a + b) > 255; end
            3'd4: begin res = (a - b + 256) % 256; c = a < b; end
            3'd5: begin
                if (acc_en) begin res = (acc_in + a) % 256; c = (acc_in + a) > 255; end
                else res = a;
            end
            3'd6: res = a;
            default: res = 255 - (a | b);
        endcase
    endfunction

    // Model state: beat waiting in stage 1, result presented at the output.
    bit         m_s1;
    int         m_a;
    int         m_b;
    logic [2:0] m_op;
    bit         m_ov;
    logic [7:0] m_res;
    logic [7:0] m_res0;
    bit         m_c;
    bit         m_c0;
    int         m_acc;
    bit         m_took;

    always @(posedge Clk) begin : model
        int r;
        int r0;
        bit c;
        bit c0;
        bit adv;
        bit ir;
        int acc_cur;
        m_took = 1'b0;
        if (!Rst_n) begin
            m_s1 = 1'b0; m_ov = 1'b0; m_res = 8'h00; m_res0 = 8'h00;
            m_c = 1'b0; m_c0 = 1'b0; m_acc = 0;
        end else begin
            adv     = !m_ov || Out_ready;
            ir      = !m_s1 || adv;
            acc_cur = Acc_clr ? 0 : m_acc;
            m_took  = In_valid && ir;
            if (m_s1 && adv) begin
                alu(m_op, m_a, m_b, acc_cur, 1'b1, r, c);
                alu(m_op, m_a, m_b, 0, 1'b0, r0, c0);
                m_res = 8'(r); m_c = c; m_res0 = 8'(r0); m_c0 = c0;
                m_ov = 1'b1;
                if (m_op == 3'd5) acc_cur = r;
            end else if (adv) begin
                m_ov = 1'b0;
            end
            m_acc = acc_cur;
            if (m_took) begin
                m_s1 = 1'b1; m_a = int'(A); m_b = int'(B); m_op = Op;
            end else if (m_s1 && adv) begin
                m_s1 = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge Clk) begin : compare
        logic exp_ir;
        if (chk_en) begin
            exp_ir = Rst_n && (!m_s1 || !m_ov || Out_ready);
            chk("in_ready", 32'(In_ready), 32'(exp_ir));
            chk("in_ready_noacc", 32'(In_ready0), 32'(exp_ir));
            chk("out_valid", 32'(Out_valid), 32'(m_ov));
            chk("out_valid_noacc", 32'(Out_valid0), 32'(m_ov));
            if (m_ov) begin
                chk("result", 32'(Result), 32'(m_res));
                chk("carry", 32'(Carry), 32'(m_c));
                chk("zero", 32'(Zero), 32'(m_res == 8'h00));
                chk("result_noacc", 32'(Result0), 32'(m_res0));
                chk("carry_noacc", 32'(Carry0), 32'(m_c0));
                chk("zero_noacc", 32'(Zero0), 32'(m_res0 == 8'h00));
            end
        end
    end

    // Beats handed to the consumer, for literal checks.
    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic [7:0] r0;
    } got_t;
    got_t got[$];

    always @(posedge Clk) begin
        if (Rst_n && Out_valid && Out_ready) begin
            got.push_back('{r: Result, c: Carry, z: Zero, r0: Result0});
        end
    end

    task automatic expect_got(input string name, input logic [7:0] r, input logic c,
                              input logic z);
        got_t g;
        if (got.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: got no output beat expected %0h", name, r);
        end else begin
            g = got.pop_front();
            chk({name, "_res"}, 32'(g.r), 32'(r));
            chk({name, "_c"}, 32'(g.c), 32'(c));
            chk({name, "_z"}, 32'(g.z), 32'(z));
        end
    endtask

    task automatic expect_got0(input string name, input logic [7:0] r);
        got_t g;
        if (got.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: got no output beat expected %0h", name, r);
        end else begin
            g = got.pop_front();
            chk({name, "_res_noacc"}, 32'(g.r0), 32'(r));
            chk({name, "_res"}, 32'(g.r), 32'(r));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Offer one beat and hold it until it is accepted (bounded).
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        In_valid = 1'b1; Op = op; A = a; B = b;
        n = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (m_took) break;
            n++;
            if (n > 50) begin
                checks++; failures++;
                $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
                break;
            end
        end
        In_valid = 1'b0;
    endtask

    initial begin : stim
        int  idx;
        bit  seen;
        int  stall;
        bit  saw_low;
        int  n;

        Rst_n = 1'b0; In_valid = 1'b1; A = 8'h00; B = 8'h00; Op = 3'd0;
        Acc_clr = 1'b0; Out_ready = 1'b1;

        // Reset with In_valid asserted
        @(posedge Clk); #1; chk_en = 1'b1;
        @(posedge Clk); #1;
        chk("rst_in_ready", 32'(In_ready), 32'd0);
        chk("rst_out_valid", 32'(Out_valid), 32'd0);
        chk("rst_result", 32'(Result), 32'h00);
        chk("rst_carry", 32'(Carry), 32'd0);
        chk("rst_zero", 32'(Zero), 32'd0);
        Rst_n = 1'b1; In_valid = 1'b0;
        @(negedge Clk);
        chk("rel_in_ready", 32'(In_ready), 32'd1);
        @(posedge Clk); #1;
        got.delete();

        // ADD / SUB
        send(3'd3, 8'hF0, 8'h20);
        idle(3);
        expect_got("add_f0_20", 8'h10, 1'b1, 1'b0);
        send(3'd4, 8'h05, 8'h05);
        send(3'd4, 8'h03, 8'h05);
        idle(3);
        expect_got("sub_5_5", 8'h00, 1'b0, 1'b1);
        expect_got("sub_3_5", 8'hFE, 1'b1, 1'b0);

        // Logic ops back-to-back
        send(3'd0, 8'hA5, 8'h0F);
        send(3'd1, 8'hA5, 8'h0F);
        send(3'd2, 8'hA5, 8'h0F);
        send(3'd6, 8'hA5, 8'h0F);
        send(3'd7, 8'hA5, 8'h0F);
        idle(3);
        expect_got("xor", 8'hAA, 1'b0, 1'b0);
        expect_got("or", 8'hAF, 1'b0, 1'b0);
        expect_got("and", 8'h05, 1'b0, 1'b0);
        expect_got("pass", 8'hA5, 1'b0, 1'b0);
        expect_got("nor", 8'h50, 1'b0, 1'b0);

        // Back-pressure: stall 3 cycles from the first valid output
        got.delete();
        idx = 0; seen = 1'b0; stall = 0; saw_low = 1'b0;
        In_valid = 1'b1; Op = 3'd0; A = 8'd1; B = 8'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge Clk); #1;
            if (m_took) idx++;
            if (idx < 4) begin
                In_valid = 1'b1; A = 8'(idx + 1);
            end else begin
                In_valid = 1'b0;
            end
            if (!seen && m_ov) begin
                seen = 1'b1; stall = 3;
            end
            if (stall > 0) begin
                Out_ready = 1'b0; stall--;
            end else begin
                Out_ready = 1'b1;
            end
            if (!In_ready) saw_low = 1'b1;
        end
        chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);
        expect_got("bp_1", 8'd1, 1'b0, 1'b0);
        expect_got("bp_2", 8'd2, 1'b0, 1'b0);
        expect_got("bp_3", 8'd3, 1'b0, 1'b0);
        expect_got("bp_4", 8'd4, 1'b0, 1'b0);
        chk("bp_no_extra", 32'(got.size()), 32'd0);

        // Accumulator
        got.delete();
        Acc_clr = 1'b1; idle(1); Acc_clr = 1'b0;
        send(3'd5, 8'h80, 8'h00);
        send(3'd5, 8'h80, 8'h00);
        send(3'd5, 8'h80, 8'h00);
        idle(3);
        expect_got("acc_1", 8'h80, 1'b0, 1'b0);
        expect_got("acc_2", 8'h00, 1'b1, 1'b1);
        expect_got("acc_3", 8'h80, 1'b0, 1'b0);
        // Clear lands on the same edge as the commit
        send(3'd5, 8'h10, 8'h00);
        Acc_clr = 1'b1; idle(1); Acc_clr = 1'b0;
        idle(3);
        expect_got("acc_clr_commit", 8'h10, 1'b0, 1'b0);

        // ACC_EN=0 instance treats ACC as PASS A
        Acc_clr = 1'b1; idle(1); Acc_clr = 1'b0;
        send(3'd5, 8'h33, 8'h00);
        idle(3);
        expect_got0("acc_disabled", 8'h33);

        // Reset while both stages are full
        Out_ready = 1'b0;
        send(3'd0, 8'h01, 8'h00);
        send(3'd0, 8'h02, 8'h00);
        Rst_n = 1'b0; idle(1); Rst_n = 1'b1;
        chk("midrst_out_valid", 32'(Out_valid), 32'd0);
        Out_ready = 1'b1;
        got.delete();
        send(3'd5, 8'h01, 8'h00);
        idle(3);
        expect_got("midrst_acc", 8'h01, 1'b0, 1'b0);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            In_valid  = ($urandom_range(0, 3) != 0);
            A         = 8'($urandom);
            B         = 8'($urandom);
            Op        = 3'($urandom);
            Out_ready = ($urandom_range(0, 2) != 0);
            Acc_clr   = ($urandom_range(0, 15) == 0);
            Rst_n     = ($urandom_range(0, 199) != 0);
            @(posedge Clk); #1;
        end
        got.delete();

        // Drain
        In_valid = 1'b0; Out_ready = 1'b1; Acc_clr = 1'b0; Rst_n = 1'b1;
        n = 0;
        while ((m_ov || m_s1) && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain_done", 32'(m_ov || m_s1), 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
